// File: rtl/key_scan_ctrl.sv
// 5x4 key matrix scanner: column drive, frame classification, press/release
// debounce FSM and a 4-entry key-code FIFO with a falling-edge read strobe.
module key_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       RSTN,
  input  logic [3:0] Key_y,
  output logic [4:0] Key_x,
  input  logic       readn,
  output logic [4:0] Key_out,
  output logic       Key_ready,
  output logic       Key_ovf
);

  localparam int          DW       = $clog2(SCAN_DIV);
  localparam logic [3:0]  DEB_LAST = 4'(DEB_SCANS);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;

  // ---------------- column scan ----------------
  logic [DW-1:0] div_cnt;
  logic [2:0]    col;
  logic          sample, frame_end;

  assign sample    = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end = sample && (col == 3'd4);
  assign Key_x     = ~(5'b00001 << col);

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      div_cnt <= '0;
      col     <= 3'd0;
    end else if (sample) begin
      div_cnt <= '0;
      col     <= (col == 3'd4) ? 3'd0 : col + 3'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // ---------------- frame classification ----------------
  logic [3:0] rows;
  logic [2:0] row_pop;
  logic [1:0] row_idx;
  logic [4:0] cur_code;
  logic [1:0] acc_n, tot_n;     // 0 = empty, 1 = single, 2 = multi
  logic [4:0] acc_code, tot_code;

  assign rows     = ~Key_y;
  assign row_pop  = 3'(rows[0]) + 3'(rows[1]) + 3'(rows[2]) + 3'(rows[3]);
  assign cur_code = {col, row_idx};

  always_comb begin
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--)
      if (rows[r]) row_idx = 2'(r);
  end

  // Include the current column so the last sample of a frame is classified
  // in the same cycle the FSM consumes the frame.
  always_comb begin
    tot_n = acc_n;
    if (row_pop == 3'd1)     tot_n = (acc_n == 2'd0) ? 2'd1 : 2'd2;
    else if (row_pop > 3'd1) tot_n = 2'd2;
    tot_code = (acc_n == 2'd0) ? cur_code : acc_code;
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      acc_n    <= 2'd0;
      acc_code <= 5'd0;
    end else if (frame_end) begin
      acc_n    <= 2'd0;
      acc_code <= 5'd0;
    end else if (sample) begin
      acc_n    <= tot_n;
      acc_code <= tot_code;
    end
  end

  // ---------------- debounce FSM ----------------
  state_t     state, state_n;
  logic [4:0] cand, cand_n;
  logic [3:0] deb_cnt, deb_cnt_n;
  logic       push;

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state   <= IDLE;
      cand    <= 5'd0;
      deb_cnt <= 4'd0;
    end else begin
      state   <= state_n;
      cand    <= cand_n;
      deb_cnt <= deb_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cand_n    = cand;
    deb_cnt_n = deb_cnt;
    push      = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (tot_n == 2'd1) begin
            cand_n    = tot_code;
            deb_cnt_n = 4'd1;
            if (DEB_SCANS == 1) begin
              state_n = HELD;
              push    = 1'b1;
            end else begin
              state_n = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (tot_n == 2'd1 && tot_code == cand) begin
            deb_cnt_n = deb_cnt + 4'd1;
            if (deb_cnt + 4'd1 >= DEB_LAST) begin
              state_n = HELD;
              push    = 1'b1;
            end
          end else if (tot_n == 2'd1) begin
            cand_n    = tot_code;
            deb_cnt_n = 4'd1;
          end else begin
            state_n   = IDLE;
            deb_cnt_n = 4'd0;
          end
        end
        HELD: begin
          if (tot_n == 2'd0) begin
            deb_cnt_n = 4'd1;
            state_n   = (DEB_SCANS == 1) ? IDLE : DEB_REL;
          end
        end
        DEB_REL: begin
          if (tot_n == 2'd0) begin
            if (deb_cnt + 4'd1 >= DEB_LAST) begin
              state_n   = IDLE;
              deb_cnt_n = 4'd0;
            end else begin
              deb_cnt_n = deb_cnt + 4'd1;
            end
          end else begin
            state_n = HELD;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // ---------------- key FIFO ----------------
  logic [4:0] mem [4];
  logic [1:0] wp, rp, wp_n, rp_n;
  logic [2:0] fcnt, fcnt_n;
  logic       readn_q, pop, wr, drop;
  logic [4:0] head_n;

  assign pop  = !readn && readn_q && (fcnt != 3'd0);
  assign wr   = push && ((fcnt != 3'd4) || pop);
  assign drop = push && (fcnt == 3'd4) && !pop;
  assign rp_n = pop ? rp + 2'd1 : rp;
  assign wp_n = wr  ? wp + 2'd1 : wp;

  always_comb begin
    fcnt_n = fcnt;
    if (wr && !pop)      fcnt_n = fcnt + 3'd1;
    else if (pop && !wr) fcnt_n = fcnt - 3'd1;
    // The written slot becomes the head when it lands where rp_n points.
    head_n = (wr && rp_n == wp) ? cand_n : mem[rp_n];
  end

  always_ff @(posedge clk) begin
    if (RSTN && wr) mem[wp] <= cand_n;
  end

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      wp        <= 2'd0;
      rp        <= 2'd0;
      fcnt      <= 3'd0;
      readn_q   <= 1'b1;
      Key_out   <= 5'd0;
      Key_ready <= 1'b0;
      Key_ovf   <= 1'b0;
    end else begin
      readn_q   <= readn;
      wp        <= wp_n;
      rp        <= rp_n;
      fcnt      <= fcnt_n;
      Key_ready <= (fcnt_n != 3'd0);
      if ((wr || pop) && fcnt_n != 3'd0) Key_out <= head_n;
      if (drop)     Key_ovf <= 1'b1;
      else if (pop) Key_ovf <= 1'b0;
    end
  end

endmodule
